// File: rtl/debug_hart_ctrl.sv
// Run-control sequencer between the debug module register file and one hart.
// Converts dmcontrol strobes into held request/acknowledge handshakes with the
// core and keeps the sticky run-control status bits that dmstatus reads back.
module debug_hart_ctrl #(
    parameter int unsigned RST_HOLD     = 4,
    parameter int unsigned HALT_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dmactive_i,
    input  logic haltreq_i,
    input  logic resumereq_i,
    input  logic ackhavereset_i,
    input  logic hartreset_i,
    input  logic setresethaltreq_i,
    input  logic clrresethaltreq_i,
    input  logic core_halted_i,
    output logic core_halt_req_o,
    output logic core_resume_req_o,
    output logic core_reset_o,
    output logic halted_o,
    output logic running_o,
    output logic resumeack_o,
    output logic havereset_o,
    output logic unavail_o,
    output logic resethaltreq_o
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED,
        ST_RESUMING,
        ST_RESET
    } state_e;

    localparam logic [7:0]  RST_HOLD_C     = 8'(RST_HOLD);
    localparam logic [15:0] HALT_TIMEOUT_C = 16'(HALT_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] halt_cnt_q, halt_cnt_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic        unavail_q, unavail_d;
    logic        resumeack_q, resumeack_d;
    logic        havereset_q, havereset_d;
    logic        resethaltreq_q, resethaltreq_d;
    logic        core_halt_req_q, core_halt_req_d;
    logic        core_resume_req_q, core_resume_req_d;
    logic        core_reset_q, core_reset_d;
    logic        halted_q, halted_d;
    logic        running_q, running_d;

    // Strobes are only honoured while the DM is active.
    logic halt_stb, resume_stb, ack_stb, set_stb, clr_stb;
    assign halt_stb   = haltreq_i & dmactive_i;
    assign resume_stb = resumereq_i & dmactive_i;
    assign ack_stb    = ackhavereset_i & dmactive_i;
    assign set_stb    = setresethaltreq_i & dmactive_i;
    assign clr_stb    = clrresethaltreq_i & dmactive_i;

    // Next-state, counters, sticky status and registered output values.
    always_comb begin
        state_d        = state_q;
        halt_cnt_d     = halt_cnt_q;
        rst_cnt_d      = rst_cnt_q;
        unavail_d      = unavail_q;
        resumeack_d    = resumeack_q;
        havereset_d    = havereset_q;
        resethaltreq_d = resethaltreq_q;

        // Acknowledge clears first so a simultaneous reset exit can re-set it.
        if (ack_stb) begin
            havereset_d = 1'b0;
        end
        // Arming wins over disarming when both arrive together.
        if (clr_stb) begin
            resethaltreq_d = 1'b0;
        end
        if (set_stb) begin
            resethaltreq_d = 1'b1;
        end

        if (hartreset_i) begin
            // Reset level overrides everything and holds the hold counter at 0.
            state_d    = ST_RESET;
            rst_cnt_d  = 8'd0;
            halt_cnt_d = 16'd0;
            unavail_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_stb) begin
                        state_d    = ST_HALTING;
                        halt_cnt_d = 16'd0;
                        unavail_d  = 1'b0;
                    end else if (core_halted_i) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_HALTING: begin
                    if (core_halted_i) begin
                        state_d    = ST_HALTED;
                        halt_cnt_d = 16'd0;
                        unavail_d  = 1'b0;
                    end else if (halt_cnt_q == HALT_TIMEOUT_C) begin
                        // Saturate and keep requesting; the hart is reported unavailable.
                        unavail_d = 1'b1;
                    end else begin
                        halt_cnt_d = halt_cnt_q + 16'd1;
                    end
                end
                ST_HALTED: begin
                    // A simultaneous halt request drops the resume.
                    if (resume_stb && !halt_stb) begin
                        state_d     = ST_RESUMING;
                        resumeack_d = 1'b0;
                    end
                end
                ST_RESUMING: begin
                    if (!core_halted_i) begin
                        state_d     = ST_RUN;
                        resumeack_d = 1'b1;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_q == RST_HOLD_C) begin
                        state_d     = resethaltreq_q ? ST_HALTING : ST_RUN;
                        halt_cnt_d  = 16'd0;
                        unavail_d   = 1'b0;
                        havereset_d = 1'b1;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        // An inactive DM aborts handshakes; a reset sequence still completes.
        if (!dmactive_i) begin
            resumeack_d    = 1'b0;
            resethaltreq_d = 1'b0;
            if (state_d != ST_RESET) begin
                state_d    = core_halted_i ? ST_HALTED : ST_RUN;
                halt_cnt_d = 16'd0;
                unavail_d  = 1'b0;
            end
        end

        core_halt_req_d   = (state_d == ST_HALTING);
        core_resume_req_d = (state_d == ST_RESUMING);
        core_reset_d      = (state_d == ST_RESET);
        halted_d          = (state_d == ST_HALTED);
        running_d         = (state_d == ST_RUN) || ((state_d == ST_HALTING) && !unavail_d);
    end

    // State, counters and all outputs registered; reset returns to RUN with havereset set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= ST_RUN;
            halt_cnt_q        <= 16'd0;
            rst_cnt_q         <= 8'd0;
            unavail_q         <= 1'b0;
            resumeack_q       <= 1'b0;
            havereset_q       <= 1'b1;
            resethaltreq_q    <= 1'b0;
            core_halt_req_q   <= 1'b0;
            core_resume_req_q <= 1'b0;
            core_reset_q      <= 1'b0;
            halted_q          <= 1'b0;
            running_q         <= 1'b1;
        end else begin
            state_q           <= state_d;
            halt_cnt_q        <= halt_cnt_d;
            rst_cnt_q         <= rst_cnt_d;
            unavail_q         <= unavail_d;
            resumeack_q       <= resumeack_d;
            havereset_q       <= havereset_d;
            resethaltreq_q    <= resethaltreq_d;
            core_halt_req_q   <= core_halt_req_d;
            core_resume_req_q <= core_resume_req_d;
            core_reset_q      <= core_reset_d;
            halted_q          <= halted_d;
            running_q         <= running_d;
        end
    end

    assign core_halt_req_o   = core_halt_req_q;
    assign core_resume_req_o = core_resume_req_q;
    assign core_reset_o      = core_reset_q;
    assign halted_o          = halted_q;
    assign running_o         = running_q;
    assign resumeack_o       = resumeack_q;
    assign havereset_o       = havereset_q;
    assign unavail_o         = unavail_q;
    assign resethaltreq_o    = resethaltreq_q;

endmodule
